// File: rtl/lag_measure_ctrl.sv
// Input-to-photon latency sequencer: flashes a patch after vsync, times the
// synchronized light-sensor response in microseconds and keeps min/max/avg stats.
module lag_measure_ctrl #(
  parameter int TICK_DIV     = 50,
  parameter int TIMEOUT_US   = 500000,
  parameter int SAMPLES_LOG2 = 4,
  parameter int MAX_FAILS    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        vsync,
  input  logic        sensor,
  output logic        flash,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        sample_valid,
  output logic        sample_timeout,
  output logic [19:0] sample_us,
  output logic [19:0] min_us,
  output logic [19:0] max_us,
  output logic [19:0] avg_us,
  output logic [8:0]  good_cnt
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int SUM_W  = 20 + SAMPLES_LOG2;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [19:0]       TIMEOUT_C = 20'(TIMEOUT_US);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [8:0]        GOOD_MAX  = 9'(2 ** SAMPLES_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FLASH,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              sync1_q, sync1_d;
  logic              s_sync_q, s_sync_d;
  logic              s_prev_q, s_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [19:0]       us_cnt_q, us_cnt_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [19:0]       run_min_q, run_min_d;
  logic [19:0]       run_max_q, run_max_d;
  logic              rel_low_q, rel_low_d;
  logic [1:0]        rel_vs_q, rel_vs_d;

  logic              flash_q, flash_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              sample_valid_q, sample_valid_d;
  logic              sample_timeout_q, sample_timeout_d;
  logic [19:0]       sample_us_q, sample_us_d;
  logic [19:0]       min_us_q, min_us_d;
  logic [19:0]       max_us_q, max_us_d;
  logic [19:0]       avg_us_q, avg_us_d;
  logic [8:0]        good_cnt_q, good_cnt_d;

  logic s_rise;
  logic vs_rise;
  logic timeout_hit;
  logic rel_exit;
  logic run_end;

  assign s_rise      = s_sync_q & ~s_prev_q;
  assign vs_rise     = vsync & ~vs_prev_q;
  assign timeout_hit = (us_cnt_q == TIMEOUT_C);
  // Release ends on the second vsync edge seen after the sensor has gone dark.
  assign rel_exit    = rel_low_q && vs_rise && (rel_vs_q == 2'd1);
  assign run_end     = (fail_cnt_q == FAIL_MAX) || (good_cnt_q == GOOD_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (start) state_d = S_ARM;
      S_ARM:
        if (abort)                       state_d = S_DONE;
        else if (vs_rise && !s_sync_q)   state_d = S_FLASH;
      S_FLASH:
        if (abort)                       state_d = S_DONE;
        else if (s_rise || timeout_hit)  state_d = S_RELEASE;
      S_RELEASE:
        if (abort)                       state_d = S_DONE;
        else if (rel_exit)               state_d = run_end ? S_DONE : S_ARM;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync1_d          = sensor;
    s_sync_d         = sync1_q;
    s_prev_d         = s_sync_q;
    vs_prev_d        = vsync;
    presc_d          = presc_q + PRE_W'(1);
    us_cnt_d         = us_cnt_q;
    fail_cnt_d       = fail_cnt_q;
    sum_d            = sum_q;
    run_min_d        = run_min_q;
    run_max_d        = run_max_q;
    rel_low_d        = rel_low_q;
    rel_vs_d         = rel_vs_q;
    flash_d          = (state_d == S_FLASH);
    done_d           = (state_q == S_DONE);
    error_d          = error_q;
    sample_valid_d   = 1'b0;
    sample_timeout_d = sample_timeout_q;
    sample_us_d      = sample_us_q;
    min_us_d         = min_us_q;
    max_us_d         = max_us_q;
    avg_us_d         = avg_us_q;
    good_cnt_d       = good_cnt_q;

    // The timebase restarts exactly when the patch is requested.
    if ((state_d == S_FLASH) && (state_q != S_FLASH)) begin
      presc_d  = '0;
      us_cnt_d = '0;
    end else if (presc_q == PRE_MAX) begin
      presc_d  = '0;
      us_cnt_d = us_cnt_q + 20'd1;
    end

    if (state_q != S_RELEASE) begin
      rel_low_d = 1'b0;
      rel_vs_d  = 2'd0;
    end else if (!rel_low_q) begin
      rel_low_d = ~s_sync_q;
    end else if (vs_rise) begin
      rel_vs_d = rel_vs_q + 2'd1;
    end

    if ((state_q == S_IDLE) && start) begin
      good_cnt_d = '0;
      fail_cnt_d = '0;
      sum_d      = '0;
      run_min_d  = '1;
      run_max_d  = '0;
      error_d    = 1'b0;
    end

    // A sensor edge takes priority over a timeout landing in the same cycle.
    if ((state_q == S_FLASH) && (state_d == S_RELEASE)) begin
      sample_valid_d = 1'b1;
      if (s_rise) begin
        sample_us_d      = us_cnt_q;
        sample_timeout_d = 1'b0;
        fail_cnt_d       = '0;
        good_cnt_d       = good_cnt_q + 9'd1;
        sum_d            = sum_q + SUM_W'(us_cnt_q);
        if (us_cnt_q < run_min_q) run_min_d = us_cnt_q;
        if (us_cnt_q > run_max_q) run_max_d = us_cnt_q;
      end else begin
        sample_us_d      = TIMEOUT_C;
        sample_timeout_d = 1'b1;
        fail_cnt_d       = fail_cnt_q + FAIL_W'(1);
      end
    end

    if ((state_q == S_RELEASE) && !abort && rel_exit) begin
      if (fail_cnt_q == FAIL_MAX) begin
        error_d = 1'b1;
      end else if (good_cnt_q == GOOD_MAX) begin
        min_us_d = run_min_q;
        max_us_d = run_max_q;
        avg_us_d = sum_q[SUM_W-1:SAMPLES_LOG2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q          <= 1'b0;
      s_sync_q         <= 1'b0;
      s_prev_q         <= 1'b0;
      vs_prev_q        <= 1'b0;
      presc_q          <= '0;
      us_cnt_q         <= '0;
      fail_cnt_q       <= '0;
      sum_q            <= '0;
      run_min_q        <= '1;
      run_max_q        <= '0;
      rel_low_q        <= 1'b0;
      rel_vs_q         <= 2'd0;
      flash_q          <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      sample_valid_q   <= 1'b0;
      sample_timeout_q <= 1'b0;
      sample_us_q      <= '0;
      min_us_q         <= '0;
      max_us_q         <= '0;
      avg_us_q         <= '0;
      good_cnt_q       <= '0;
    end else begin
      sync1_q          <= sync1_d;
      s_sync_q         <= s_sync_d;
      s_prev_q         <= s_prev_d;
      vs_prev_q        <= vs_prev_d;
      presc_q          <= presc_d;
      us_cnt_q         <= us_cnt_d;
      fail_cnt_q       <= fail_cnt_d;
      sum_q            <= sum_d;
      run_min_q        <= run_min_d;
      run_max_q        <= run_max_d;
      rel_low_q        <= rel_low_d;
      rel_vs_q         <= rel_vs_d;
      flash_q          <= flash_d;
      done_q           <= done_d;
      error_q          <= error_d;
      sample_valid_q   <= sample_valid_d;
      sample_timeout_q <= sample_timeout_d;
      sample_us_q      <= sample_us_d;
      min_us_q         <= min_us_d;
      max_us_q         <= max_us_d;
      avg_us_q         <= avg_us_d;
      good_cnt_q       <= good_cnt_d;
    end
  end

  assign flash          = flash_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign sample_valid   = sample_valid_q;
  assign sample_timeout = sample_timeout_q;
  assign sample_us      = sample_us_q;
  assign min_us         = min_us_q;
  assign max_us         = max_us_q;
  assign avg_us         = avg_us_q;
  assign good_cnt       = good_cnt_q;

endmodule

// File: tb/tb_lag_measure_ctrl.sv
// Randomized bench for lag_measure_ctrl: a free-running vsync, a sensor model
// driven per sample, and expected latencies/stats computed from plain arithmetic.
module tb_lag_measure_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int TIMEOUT_US   = 200;
  localparam int SAMPLES_LOG2 = 2;
  localparam int MAX_FAILS    = 2;
  localparam int N_SAMPLES    = 1 << SAMPLES_LOG2;
  localparam int VS_PERIOD    = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        vsync = 1'b0;
  logic        sensor = 1'b0;
  logic        flash;
  logic        busy;
  logic        done;
  logic        error;
  logic        sample_valid;
  logic        sample_timeout;
  logic [19:0] sample_us;
  logic [19:0] min_us;
  logic [19:0] max_us;
  logic [19:0] avg_us;
  logic [8:0]  good_cnt;

  int check_count = 0;
  int pass_count  = 0;
  int exp_min = 0;
  int exp_max = 0;
  int exp_avg = 0;
  int run_us[$];
  int delay_q[$];

  always #5 clk = ~clk;

  lag_measure_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .TIMEOUT_US  (TIMEOUT_US),
    .SAMPLES_LOG2(SAMPLES_LOG2),
    .MAX_FAILS   (MAX_FAILS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .vsync         (vsync),
    .sensor        (sensor),
    .flash         (flash),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .sample_valid  (sample_valid),
    .sample_timeout(sample_timeout),
    .sample_us     (sample_us),
    .min_us        (min_us),
    .max_us        (max_us),
    .avg_us        (avg_us),
    .good_cnt      (good_cnt)
  );

  // One-cycle vsync pulse every VS_PERIOD cycles, driven just after the edge.
  initial begin
    forever begin
      repeat (VS_PERIOD - 1) @(posedge clk);
      #1 vsync = 1'b1;
      @(posedge clk);
      #1 vsync = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic do_start, input logic do_abort);
    @(posedge clk);
    #1;
    start = do_start;
    abort = do_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flash"}, int'(flash), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_error"}, int'(error), 0);
    checkOutput({tag, "_sample_valid"}, int'(sample_valid), 0);
    checkOutput({tag, "_sample_timeout"}, int'(sample_timeout), 0);
    checkOutput({tag, "_sample_us"}, int'(sample_us), 0);
    checkOutput({tag, "_min"}, int'(min_us), 0);
    checkOutput({tag, "_max"}, int'(max_us), 0);
    checkOutput({tag, "_avg"}, int'(avg_us), 0);
    checkOutput({tag, "_good_cnt"}, int'(good_cnt), 0);
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, "_min"}, int'(min_us), exp_min);
    checkOutput({tag, "_max"}, int'(max_us), exp_max);
    checkOutput({tag, "_avg"}, int'(avg_us), exp_avg);
  endtask

  // Waits for flash to rise and confirms a vsync pulse was present the cycle before.
  task automatic waitFlash(input string tag);
    logic prev_vs = 1'b0;
    logic seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (flash) begin
        seen = 1'b1;
        break;
      end
      prev_vs = vsync;
    end
    checkOutput({tag, "_flash_rise"}, int'(seen), 1);
    if (seen) checkOutput({tag, "_flash_after_vsync"}, int'(prev_vs), 1);
  endtask

  // Sensor edge driven `delay` cycles after flash is seen reaches the detector two
  // cycles later, so the expected reading is floor((delay + 2) / TICK_DIV).
  task automatic doSample(input int delay, input logic expect_to, input string tag);
    int   exp_us;
    logic got = 1'b0;
    waitFlash(tag);
    if (!expect_to) begin
      repeat (delay) @(posedge clk);
      #1 sensor = 1'b1;
    end
    for (int i = 0; i < TIMEOUT_US * TICK_DIV + 100; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_valid"}, int'(got), 1);
    exp_us = expect_to ? TIMEOUT_US : (delay + 2) / TICK_DIV;
    checkOutput({tag, "_timeout"}, int'(sample_timeout), int'(expect_to));
    checkOutput({tag, "_us"}, int'(sample_us), exp_us);
    if (!expect_to) run_us.push_back(exp_us);
    @(posedge clk);
    #1 sensor = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done"}, int'(seen), 1);
    checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, int'(done), 0);
  endtask

  task automatic startRun(input string tag);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_busy"}, int'(busy), 1);
    checkOutput({tag, "_error_clr"}, int'(error), 0);
    checkOutput({tag, "_good_clr"}, int'(good_cnt), 0);
  endtask

  task automatic runGood(input string tag);
    int mn;
    int mx;
    int sum;
    run_us.delete();
    startRun(tag);
    for (int i = 0; i < N_SAMPLES; i++) doSample(delay_q[i], 1'b0, $sformatf("%s_s%0d", tag, i));
    mn = 1 << 20;
    mx = 0;
    sum = 0;
    foreach (run_us[i]) begin
      if (run_us[i] < mn) mn = run_us[i];
      if (run_us[i] > mx) mx = run_us[i];
      sum += run_us[i];
    end
    exp_min = mn;
    exp_max = mx;
    exp_avg = sum / N_SAMPLES;
    waitDone(tag);
    checkOutput({tag, "_error"}, int'(error), 0);
    checkOutput({tag, "_good_cnt"}, int'(good_cnt), N_SAMPLES);
    checkStats(tag);
  endtask

  task automatic randomDelays();
    delay_q.delete();
    for (int i = 0; i < N_SAMPLES; i++) delay_q.push_back(int'($urandom_range(700, 1)));
  endtask

  initial begin
    logic stuck_flash;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    delay_q = '{400, 400, 400, 400};
    runGood("nominal");

    delay_q = '{158, 318, 478, 638};
    runGood("varying");

    for (int r = 0; r < 2; r++) begin
      randomDelays();
      runGood($sformatf("random%0d", r));
    end

    startRun("timeout");
    for (int i = 0; i < MAX_FAILS; i++) doSample(0, 1'b1, $sformatf("timeout_s%0d", i));
    waitDone("timeout");
    checkOutput("timeout_error", int'(error), 1);
    checkOutput("timeout_good_cnt", int'(good_cnt), 0);
    checkStats("timeout_keep");

    sensor = 1'b1;
    repeat (3) @(posedge clk);
    startRun("stuck");
    stuck_flash = 1'b0;
    for (int i = 0; i < 4 * VS_PERIOD; i++) begin
      @(negedge clk);
      if (flash) stuck_flash = 1'b1;
    end
    checkOutput("stuck_no_flash", int'(stuck_flash), 0);
    checkOutput("stuck_busy", int'(busy), 1);
    @(posedge clk);
    #1 sensor = 1'b0;
    waitFlash("stuck");

    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("busy_start_flash", int'(flash), 1);
    checkOutput("busy_start_busy", int'(busy), 1);

    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort_flash_low", int'(flash), 0);
    checkOutput("abort_done_early", int'(done), 0);
    @(negedge clk);
    checkOutput("abort_done", int'(done), 1);
    checkOutput("abort_busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("abort_done_pulse", int'(done), 0);
    checkOutput("abort_error", int'(error), 0);
    checkStats("abort_keep");

    applyStimulus(1'b1, 1'b0);
    waitFlash("rst");
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("midrst");
    exp_min = 0;
    exp_max = 0;
    exp_avg = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_busy", int'(busy), 0);
    checkOutput("post_rst_flash", int'(flash), 0);

    randomDelays();
    runGood("recover");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
